ccip_mmio_csr: RTL

MMIO control/status register file sitting directly downstream of the CCI-P interface registers, inside `wrapper`. It decodes MMIO read/write requests arriving on CCI-P Rx channel c0 and returns read responses on Tx channel c2. It exposes the mandatory AFU DFH and UUID, plus the control registers the ODE solver kernel uses to start, report status and locate its host buffer.

---
 rtl/ccip_mmio_csr_pkg.sv | 86 ++++++++
 rtl/ccip_mmio_csr_if.sv | 20 ++
 rtl/ccip_mmio_rd_pipe.sv | 60 ++++++
 rtl/ccip_mmio_csr.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/ccip_mmio_csr_pkg.sv
// CCI-P MMIO CSR types, register offsets and helpers.
// Shared by the CSR top, its read pipe and the bus interface.
package ccip_csr_pkg;

  typedef logic [41:0] t_ccip_clAddr;
  typedef logic [8:0]  t_ccip_tid;
  typedef logic [14:0] t_csr_idx;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd;
    t_ccip_tid   tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    logic [27:0]  hdr;
    logic [511:0] data;
    logic         rspValid;
    logic         mmioRdValid;
    logic         mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    logic           c0TxAlmFull;
    logic           c1TxAlmFull;
    t_if_ccip_c0_Rx c0;
  } t_if_ccip_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  localparam logic [15:0] CSR_DFH       = 16'h0000;
  localparam logic [15:0] CSR_AFU_ID_L  = 16'h0008;
  localparam logic [15:0] CSR_AFU_ID_H  = 16'h0010;
  localparam logic [15:0] CSR_RSVD0     = 16'h0018;
  localparam logic [15:0] CSR_RSVD1     = 16'h0020;
  localparam logic [15:0] CSR_SCRATCH   = 16'h0028;
  localparam logic [15:0] CSR_CTRL      = 16'h0030;
  localparam logic [15:0] CSR_STATUS    = 16'h0038;
  localparam logic [15:0] CSR_BUF_ADDR  = 16'h0040;
  localparam logic [15:0] CSR_CYCLE_CNT = 16'h0048;

  localparam t_csr_idx IDX_DFH   = t_csr_idx'(CSR_DFH >> 3);
  localparam t_csr_idx IDX_ID_L  = t_csr_idx'(CSR_AFU_ID_L >> 3);
  localparam t_csr_idx IDX_ID_H  = t_csr_idx'(CSR_AFU_ID_H >> 3);
  localparam t_csr_idx IDX_SCR   = t_csr_idx'(CSR_SCRATCH >> 3);
  localparam t_csr_idx IDX_CTRL  = t_csr_idx'(CSR_CTRL >> 3);
  localparam t_csr_idx IDX_STAT  = t_csr_idx'(CSR_STATUS >> 3);
  localparam t_csr_idx IDX_BUF   = t_csr_idx'(CSR_BUF_ADDR >> 3);
  localparam t_csr_idx IDX_CYCLE = t_csr_idx'(CSR_CYCLE_CNT >> 3);

  localparam logic [3:0] DFH_TYPE_AFU = 4'h1;

  function automatic logic [63:0] dfh_word(
    input logic [23:0] next_offset
  );
    logic eol;
    eol = (next_offset == 24'h0);
    return {DFH_TYPE_AFU, 19'h0, eol,
            next_offset, 16'h0};
  endfunction

  // A 4 B write lands in the dword picked by the
  // address LSB; the other half keeps its old value.
  function automatic logic [63:0] wr_merge(
    input logic [63:0] old_val,
    input logic [63:0] wdata,
    input logic [1:0]  len,
    input logic        dw_hi
  );
    if (len != 2'd0)
      return wdata;
    if (dw_hi)
      return {wdata[31:0], old_val[31:0]};
    return {old_val[63:32], wdata[31:0]};
  endfunction

endpackage

// File: rtl/ccip_mmio_csr_if.sv
// CCI-P MMIO request/response bundle between the shell
// registers (master) and the CSR file (slave).
interface ccip_mmio_csr_if
  import ccip_csr_pkg::*;
();

  t_if_ccip_Rx    cp2af_sRxPort;
  t_if_ccip_c2_Tx af2cp_sTxC2;

  modport master (
    output cp2af_sRxPort,
    input  af2cp_sTxC2
  );

  modport slave (
    input  cp2af_sRxPort,
    output af2cp_sTxC2
  );

endinterface

// File: rtl/ccip_mmio_rd_pipe.sv
// Two-stage MMIO read response pipeline: request
// capture, then dword select and c2 response register.
module ccip_mmio_rd_pipe
  import ccip_csr_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           i_rd_valid,
  input  t_ccip_tid      i_tid,
  input  logic [1:0]     i_len,
  input  logic           i_dw_hi,
  input  logic [63:0]    i_data,
  output t_if_ccip_c2_Tx o_c2
);

  logic           r_s1_valid;
  t_ccip_tid      r_s1_tid;
  logic [1:0]     r_s1_len;
  logic           r_s1_dw_hi;
  logic [63:0]    r_s1_data;
  logic [63:0]    w_rsp_data;
  t_if_ccip_c2_Tx r_c2;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_tid   <= '0;
      r_s1_len   <= '0;
      r_s1_dw_hi <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= i_rd_valid;
      r_s1_tid   <= i_tid;
      r_s1_len   <= i_len;
      r_s1_dw_hi <= i_dw_hi;
      r_s1_data  <= i_data;
    end
  end

  always_comb begin
    w_rsp_data = r_s1_data;
    if (r_s1_len == 2'd0)
      w_rsp_data = r_s1_dw_hi ?
        {32'h0, r_s1_data[63:32]} :
        {32'h0, r_s1_data[31:0]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_c2 <= '0;
    end else begin
      r_c2.mmioRdValid <= r_s1_valid;
      r_c2.hdr.tid     <= r_s1_tid;
      r_c2.data        <= w_rsp_data;
    end
  end

  assign o_c2 = r_c2;

endmodule

// File: rtl/ccip_mmio_csr.sv
// CCI-P MMIO CSR file: DFH/UUID, scratch, kernel control.
// Define CSR_PERF_CNT_EN to add the busy-cycle counter.
module ccip_mmio_csr
  import ccip_csr_pkg::*;
#(
  parameter logic [63:0] AFU_ID_L        = 64'h0,
  parameter logic [63:0] AFU_ID_H        = 64'h0,
  parameter logic [23:0] NEXT_DFH_OFFSET = 24'h0
) (
  input  logic                  clk,
  input  logic                  reset,
  ccip_mmio_csr_if.slave        ccip,
  output logic                  start,
  output logic                  kernel_rst,
  output t_ccip_clAddr          buf_addr,
  input  logic                  kernel_busy,
  input  logic                  kernel_done
);

  t_ccip_c0_ReqMmioHdr w_hdr;
  t_csr_idx            w_idx;
  logic                w_dw_hi;
  logic                w_wr;
  logic                w_rd;
  logic [63:0]         w_wdata;
  logic [63:0]         w_rdata;
  logic [63:0]         w_cycle_cnt;
  logic [63:0]         w_scr_new;
  logic [63:0]         w_buf_new;
  logic [63:0]         w_ctrl;
  logic                w_start_wr;
  logic                w_krst_wr;
  logic                w_unused;
  t_if_ccip_c2_Tx      w_c2;

  logic [63:0]         r_scratch;
  t_ccip_clAddr        r_buf_addr;
  logic                r_done_sticky;
  logic                r_start;
  logic                r_kernel_rst;

  assign w_hdr   = t_ccip_c0_ReqMmioHdr'(
                     ccip.cp2af_sRxPort.c0.hdr);
  assign w_idx   = w_hdr.address[15:1];
  assign w_dw_hi = w_hdr.address[0];
  assign w_wr    = ccip.cp2af_sRxPort.c0.mmioWrValid;
  assign w_rd    = ccip.cp2af_sRxPort.c0.mmioRdValid;
  assign w_wdata = ccip.cp2af_sRxPort.c0.data[63:0];

  // Read data is muxed on the request cycle so a write
  // in the same cycle is not yet visible to the read.
  always_comb begin
    w_rdata = '0;
    unique case (1'b1)
      (w_idx == IDX_DFH):
        w_rdata = dfh_word(NEXT_DFH_OFFSET);
      (w_idx == IDX_ID_L):
        w_rdata = AFU_ID_L;
      (w_idx == IDX_ID_H):
        w_rdata = AFU_ID_H;
      (w_idx == IDX_SCR):
        w_rdata = r_scratch;
      (w_idx == IDX_STAT):
        w_rdata = {62'h0, r_done_sticky, kernel_busy};
      (w_idx == IDX_BUF):
        w_rdata = {22'h0, r_buf_addr};
      (w_idx == IDX_CYCLE):
        w_rdata = w_cycle_cnt;
      default:
        w_rdata = '0;
    endcase
  end

  assign w_scr_new = wr_merge(r_scratch, w_wdata,
                       w_hdr.length, w_dw_hi);
  assign w_buf_new = wr_merge({22'h0, r_buf_addr},
                       w_wdata, w_hdr.length, w_dw_hi);
  assign w_ctrl    = wr_merge(64'h0, w_wdata,
                       w_hdr.length, w_dw_hi);

  assign w_start_wr = w_wr & (w_idx == IDX_CTRL)
                    & w_ctrl[0];
  assign w_krst_wr  = w_wr & (w_idx == IDX_CTRL)
                    & w_ctrl[1];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_scratch     <= '0;
      r_buf_addr    <= '0;
      r_done_sticky <= 1'b0;
      r_start       <= 1'b0;
      r_kernel_rst  <= 1'b0;
    end else begin
      r_start      <= w_start_wr;
      r_kernel_rst <= w_krst_wr;
      if (w_wr && (w_idx == IDX_SCR))
        r_scratch <= w_scr_new;
      if (w_wr && (w_idx == IDX_BUF))
        r_buf_addr <= w_buf_new[41:0];
      if (w_start_wr)
        r_done_sticky <= 1'b0;
      else if (kernel_done)
        r_done_sticky <= 1'b1;
    end
  end

`ifdef CSR_PERF_CNT_EN
  logic [63:0] r_cycle_cnt;

  always_ff @(posedge clk) begin
    if (reset)
      r_cycle_cnt <= '0;
    else if (w_start_wr)
      r_cycle_cnt <= '0;
    else if (kernel_busy)
      r_cycle_cnt <= r_cycle_cnt + 64'd1;
  end

  assign w_cycle_cnt = r_cycle_cnt;
`else
  assign w_cycle_cnt = '0;
`endif

  ccip_mmio_rd_pipe u_rd_pipe (
    .clk        (clk),
    .reset      (reset),
    .i_rd_valid (w_rd),
    .i_tid      (w_hdr.tid),
    .i_len      (w_hdr.length),
    .i_dw_hi    (w_dw_hi),
    .i_data     (w_rdata),
    .o_c2       (w_c2)
  );

  assign ccip.af2cp_sTxC2 = w_c2;
  assign start            = r_start;
  assign kernel_rst       = r_kernel_rst;
  assign buf_addr         = r_buf_addr;

  assign w_unused = ^{ccip.cp2af_sRxPort.c0TxAlmFull,
                      ccip.cp2af_sRxPort.c1TxAlmFull,
                      ccip.cp2af_sRxPort.c0.rspValid,
                      ccip.cp2af_sRxPort.c0.data[511:64],
                      w_hdr.rsvd,
                      w_buf_new[63:42],
                      w_ctrl[63:2]};

endmodule
